// File: rtl/spi_rom_reader.sv
// SPI NOR byte fetcher for the 8-bit core: one-entry last-byte cache,
// sequential streaming with chip select held low between fetches.
module spi_rom_reader #(
    parameter int CLK_DIV        = 2,
    parameter int HOLD_CYCLES    = 64,
    parameter int CS_HIGH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [15:0] addr,
    output logic        busy,
    output logic        done,
    output logic [7:0]  data,
    output logic        spi_sclk,
    output logic        spi_cs_n,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int GW = $clog2(CS_HIGH_CYCLES + 1);

    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(CS_HIGH_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CS_GAP,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_HOLD,
        S_HIT
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [5:0]    bit_cnt_q, bit_cnt_d;
    logic [31:0]   shift_q, shift_d;
    logic [7:0]    rx_q, rx_d;
    logic          sclk_q, sclk_d;
    logic          cs_n_q, cs_n_d;
    logic          mosi_q, mosi_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [7:0]    data_q, data_d;
    logic [15:0]   last_addr_q, last_addr_d;
    logic          valid_q, valid_d;
    logic [15:0]   req_addr_q, req_addr_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic          gap_rd_q, gap_rd_d;
    logic          hit_hold_q, hit_hold_d;
    logic          pend_q, pend_d;
    logic [15:0]   pend_addr_q, pend_addr_d;

    logic          req_ok;
    logic          idle_req;
    logic [15:0]   idle_addr;
    logic [15:0]   start_addr;
    logic [31:0]   frame;
    logic          seq_ok;
    logic          go_read;

    assign req_ok     = req & ~busy_q;
    assign idle_req   = req_ok | pend_q;
    assign idle_addr  = req_ok ? addr : pend_addr_q;
    assign start_addr = (state_q == S_IDLE) ? idle_addr : req_addr_q;
    assign frame      = {8'h03, 8'h00, start_addr};
    // 16'hFFFF -> 16'h0000 deliberately does not count as sequential
    assign seq_ok     = (last_addr_q != 16'hFFFF)
                      && (addr == last_addr_q + 16'd1);

    always_comb begin
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_d        = rx_q;
        sclk_d      = sclk_q;
        cs_n_d      = cs_n_q;
        mosi_d      = mosi_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        data_d      = data_q;
        last_addr_d = last_addr_q;
        valid_d     = valid_q;
        req_addr_d  = req_addr_q;
        hold_cnt_d  = hold_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        gap_rd_d    = gap_rd_q;
        hit_hold_d  = hit_hold_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        go_read     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (idle_req) begin
                    pend_d     = 1'b0;
                    req_addr_d = idle_addr;
                    busy_d     = 1'b1;
                    if (valid_q && idle_addr == last_addr_q) begin
                        state_d    = S_HIT;
                        done_d     = 1'b1;
                        hit_hold_d = 1'b0;
                    end else begin
                        go_read = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (req_ok) begin
                    req_addr_d = addr;
                    busy_d     = 1'b1;
                    if (addr == last_addr_q) begin
                        state_d    = S_HIT;
                        done_d     = 1'b1;
                        hit_hold_d = 1'b1;
                    end else if (seq_ok) begin
                        state_d   = S_DATA;
                        bit_cnt_d = 6'd8;
                        div_cnt_d = '0;
                        sclk_d    = 1'b0;
                        mosi_d    = 1'b0;
                    end else begin
                        state_d   = S_CS_GAP;
                        cs_n_d    = 1'b1;
                        gap_cnt_d = GAP_LAST;
                        gap_rd_d  = 1'b1;
                    end
                end else if (hold_cnt_q >= HOLD_LAST) begin
                    state_d   = S_CS_GAP;
                    cs_n_d    = 1'b1;
                    gap_cnt_d = GAP_LAST;
                    gap_rd_d  = 1'b0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            S_HIT: begin
                state_d = hit_hold_q ? S_HOLD : S_IDLE;
                // the HIT cycle itself is the first idle cycle of the hold
                hold_cnt_d = HW'(1);
            end
            S_CS_GAP: begin
                busy_d = gap_rd_q;
                if (!gap_rd_q && req) begin
                    pend_d      = 1'b1;
                    pend_addr_d = addr;
                end
                if (gap_cnt_q == '0) begin
                    if (gap_rd_q) begin
                        go_read = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - GW'(1);
                end
            end
            S_CMD, S_ADDR, S_DATA: begin
                busy_d = 1'b1;
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    sclk_d    = ~sclk_q;
                    if (!sclk_q) begin
                        if (state_q == S_DATA) begin
                            rx_d = {rx_q[6:0], spi_miso};
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q - 6'd1;
                        mosi_d    = shift_q[31];
                        shift_d   = {shift_q[30:0], 1'b0};
                        if (state_q == S_CMD && bit_cnt_q == 6'd33) begin
                            state_d = S_ADDR;
                        end else if (state_q == S_ADDR
                                     && bit_cnt_q == 6'd9) begin
                            state_d = S_DATA;
                            mosi_d  = 1'b0;
                        end else if (state_q == S_DATA) begin
                            mosi_d = 1'b0;
                            if (bit_cnt_q == 6'd1) begin
                                state_d     = S_HOLD;
                                done_d      = 1'b1;
                                data_d      = rx_q;
                                last_addr_d = req_addr_q;
                                valid_d     = 1'b1;
                                hold_cnt_d  = '0;
                            end
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (go_read) begin
            state_d   = S_CMD;
            cs_n_d    = 1'b0;
            sclk_d    = 1'b0;
            div_cnt_d = '0;
            bit_cnt_d = 6'd40;
            mosi_d    = frame[31];
            shift_d   = {frame[30:0], 1'b0};
            busy_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            div_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rx_q        <= '0;
            sclk_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            data_q      <= 8'h00;
            last_addr_q <= '0;
            valid_q     <= 1'b0;
            req_addr_q  <= '0;
            hold_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            gap_rd_q    <= 1'b0;
            hit_hold_q  <= 1'b0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_q        <= rx_d;
            sclk_q      <= sclk_d;
            cs_n_q      <= cs_n_d;
            mosi_q      <= mosi_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            data_q      <= data_d;
            last_addr_q <= last_addr_d;
            valid_q     <= valid_d;
            req_addr_q  <= req_addr_d;
            hold_cnt_q  <= hold_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            gap_rd_q    <= gap_rd_d;
            hit_hold_q  <= hit_hold_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign data     = data_q;
    assign spi_sclk = sclk_q;
    assign spi_cs_n = cs_n_q;
    assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_rom_reader.sv
// Randomized bench for spi_rom_reader: behavioural SPI flash plus a
// transaction-level latency/data model of the fetch unit.
module tb_spi_rom_reader;

    localparam int CD   = 2;
    localparam int HOLD = 64;
    localparam int CH   = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [15:0] addr;
    logic        busy;
    logic        done;
    logic [7:0]  data;
    logic        spi_sclk;
    logic        spi_cs_n;
    logic        spi_mosi;
    logic        miso_r = 1'b0;

    spi_rom_reader #(
        .CLK_DIV(CD),
        .HOLD_CYCLES(HOLD),
        .CS_HIGH_CYCLES(CH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .addr(addr),
        .busy(busy),
        .done(done),
        .data(data),
        .spi_sclk(spi_sclk),
        .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi),
        .spi_miso(miso_r)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    // Behavioural SPI NOR flash, mode 0, sampled mid-cycle
    logic [7:0]  mem [0:65535];
    int          fl_cnt = 0;
    logic [31:0] fl_sr = '0;
    logic [23:0] fl_addr = '0;
    logic [31:0] last_frame = '0;
    int          frames = 0;
    int          rises = 0;
    int          mosi_bad = 0;
    logic        pv_sclk = 1'b0;
    logic        pv_mosi = 1'b0;

    always @(negedge clk) begin
        if (spi_sclk === 1'b1 && pv_sclk && spi_mosi !== pv_mosi)
            mosi_bad++;
        if (spi_cs_n !== 1'b0) begin
            fl_cnt = 0;
        end else if (spi_sclk && !pv_sclk) begin
            rises++;
            if (fl_cnt >= 32 && spi_mosi) mosi_bad++;
            if (fl_cnt < 32) fl_sr = {fl_sr[30:0], spi_mosi};
            fl_cnt++;
            if (fl_cnt == 32) begin
                fl_addr    = fl_sr[23:0];
                last_frame = fl_sr;
                frames++;
            end
        end else if (!spi_sclk && pv_sclk && fl_cnt >= 32) begin
            automatic int k = fl_cnt - 32;
            automatic logic [15:0] ix = 16'(fl_addr + 24'(k / 8));
            automatic logic [7:0] b = mem[ix];
            miso_r = b[7 - (k % 8)];
        end
        pv_sclk = spi_sclk;
        pv_mosi = spi_mosi;
    end

    // Transaction-level model state
    bit          m_valid = 0;
    bit          m_hold = 0;
    logic [15:0] m_last = '0;
    int          m_done = 0;

    task automatic run_txn(input logic [15:0] a, input int dly,
                           output int lat);
        int r, t0, exp_done, exp_lat, r0, f0, n;
        bit in_hold, hit, seq, full;
        while (cyc < m_done + dly) @(negedge clk);
        r = cyc;
        in_hold = m_hold && (r - m_done < HOLD);
        t0 = r;
        if (m_hold && !in_hold && (m_done + HOLD + CH > r))
            t0 = m_done + HOLD + CH;
        hit  = m_valid && (a == m_last);
        seq  = !hit && in_hold && (m_last != 16'hFFFF)
             && (a == m_last + 16'd1);
        full = !hit && !seq;
        if (hit)          exp_lat = 1;
        else if (seq)     exp_lat = 1 + 16 * CD;
        else if (in_hold) exp_lat = 1 + CH + 80 * CD;
        else              exp_lat = 1 + 80 * CD;
        exp_done = t0 + exp_lat;
        r0 = rises;
        f0 = frames;
        req  = 1'b1;
        addr = a;
        @(negedge clk);
        req = 1'b0;
        n = 0;
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            chk("done_seen", 32'd0, 32'd1);
            lat = -1;
            m_hold = 0;
            m_done = cyc;
            return;
        end
        lat = cyc - r;
        chk("done_cycle", cyc, exp_done);
        chk("data", {24'd0, data}, {24'd0, mem[a]});
        chk("busy_at_done", {31'd0, busy}, 32'd1);
        chk("sclk_rises", rises - r0, hit ? 0 : (seq ? 8 : 40));
        chk("frames", frames - f0, full ? 1 : 0);
        chk("cs_n_at_done", {31'd0, spi_cs_n},
            (hit && !in_hold) ? 32'd1 : 32'd0);
        if (full) chk("cmd_addr", last_frame, {8'h03, 8'h00, a});
        m_valid = 1;
        m_last  = a;
        m_done  = cyc;
        m_hold  = hit ? in_hold : 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat;
        int d0;
        logic [15:0] a;
        logic [15:0] saved;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'h0012] = 8'hA5;
        mem[16'h0013] = 8'h3C;
        rst_n = 1'b0;
        req   = 1'b0;
        addr  = '0;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", {31'd0, spi_cs_n}, 32'd1);
        chk("rst_sclk", {31'd0, spi_sclk}, 32'd0);
        chk("rst_mosi", {31'd0, spi_mosi}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_data", {24'd0, data}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        m_done = cyc;

        run_txn(16'h0012, 2, lat);
        chk("tp_full_lat", lat, 161);
        chk("tp_full_data", {24'd0, data}, 32'h00A5);
        run_txn(16'h0013, 5, lat);
        chk("tp_stream_lat", lat, 33);
        chk("tp_stream_data", {24'd0, data}, 32'h003C);
        run_txn(16'h0013, 3, lat);
        chk("tp_hit_lat", lat, 1);
        run_txn(16'h0200, 4, lat);
        chk("tp_hold_miss_lat", lat, 163);

        d0 = m_done;
        while (cyc < d0 + 60) @(negedge clk);
        chk("hold_cs_low", {31'd0, spi_cs_n}, 32'd0);
        while (cyc < d0 + 68) @(negedge clk);
        chk("timeout_cs_high", {31'd0, spi_cs_n}, 32'd1);

        run_txn(16'hFFFF, 80, lat);
        chk("tp_ffff_lat", lat, 161);
        run_txn(16'h0000, 3, lat);
        chk("tp_wrap_lat", lat, 163);
        run_txn(16'h0001, 63, lat);
        chk("expiry_req_lat", lat, 33);
        run_txn(16'h0700, 64, lat);
        chk("gap_pending_lat", lat, 163);

        for (int i = 0; i < 40; i++) begin
            int sel;
            int dly;
            sel = $urandom_range(0, 9);
            if (sel < 4)      a = m_last + 16'd1;
            else if (sel < 6) a = m_last;
            else              a = 16'($urandom_range(0, 16'h00FF));
            dly = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 20)
                                              : $urandom_range(70, 100);
            run_txn(a, dly, lat);
        end

        saved = 16'h0345;
        run_txn(saved, 90, lat);
        while (cyc < m_done + 5) @(negedge clk);
        req  = 1'b1;
        addr = 16'h1234;
        @(negedge clk);
        req = 1'b0;
        repeat (60) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_cs_n", {31'd0, spi_cs_n}, 32'd1);
        chk("midrst_sclk", {31'd0, spi_sclk}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_valid = 0;
        m_hold  = 0;
        m_done  = cyc;
        run_txn(saved, 2, lat);
        chk("post_rst_full_lat", lat, 161);

        chk("mosi_rules", mosi_bad, 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
